// File: rtl/rtcl_p3s7_hs_pkg.sv
// Shared constants for the PYTHON300 HS D-PHY sender: FSM state codes,
// bus-width derivations and the default inter-burst gap.
package rtcl_p3s7_hs_pkg;

    localparam int GAP_CYCLES_DEF = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    function automatic int beat_bits(input int lanes);
        return lanes * 8;
    endfunction

    function automatic int pix_bits(input int channels, input int raw_bits);
        return channels * raw_bits;
    endfunction

endpackage

// File: rtl/fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO, depth 2^PTR_BITS.
// Read data is valid combinationally while o_rd_vld; o_wr_rdy drops when full.
module fifo_fwft #(
    parameter int WIDTH    = 8,
    parameter int PTR_BITS = 4
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    output logic             o_wr_rdy,
    output logic             o_rd_vld,
    output logic [WIDTH-1:0] o_rd_dat,
    input  logic             i_rd_rdy
);
    logic [WIDTH-1:0]  r_mem [2**PTR_BITS];
    logic [PTR_BITS:0] r_wr_ptr;
    logic [PTR_BITS:0] r_rd_ptr;
    logic              w_full;
    logic              w_empty;

    assign w_full   = (r_wr_ptr[PTR_BITS] != r_rd_ptr[PTR_BITS]) &&
                      (r_wr_ptr[PTR_BITS-1:0] == r_rd_ptr[PTR_BITS-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_wr_rdy = !w_full;
    assign o_rd_vld = !w_empty;
    assign o_rd_dat = r_mem[r_rd_ptr[PTR_BITS-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_wr_vld && !w_full)
            r_mem[r_wr_ptr[PTR_BITS-1:0]] <= i_wr_dat;
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_vld && !w_full)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_rdy && !w_empty)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rtcl_p3s7_hs_pack.sv
// Packs PIX_BITS pixels LSB-first into BEAT_BITS beats; s_last flushes a zero-padded
// residue beat flagged last. One beat per cycle; s_ready drops while a beat is stuck.
module rtcl_p3s7_hs_pack #(
    parameter int PIX_BITS  = 10,
    parameter int BEAT_BITS = 16
) (
    input  logic                 dphy_clk,
    input  logic                 aresetn,
    input  logic [PIX_BITS-1:0]  i_s_data,
    input  logic                 i_s_last,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    output logic [BEAT_BITS-1:0] o_beat_dat,
    output logic                 o_beat_last,
    output logic                 o_beat_vld,
    input  logic                 i_beat_rdy
);
    localparam int ACC_BITS = BEAT_BITS + PIX_BITS;
    localparam int CNT_BITS = $clog2(ACC_BITS + 1);
    localparam logic [CNT_BITS-1:0] BEAT_CNT = CNT_BITS'(BEAT_BITS);
    localparam logic [CNT_BITS-1:0] PIX_CNT  = CNT_BITS'(PIX_BITS);

    logic [ACC_BITS-1:0] r_acc;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_flush;
    logic                r_run;
    logic [ACC_BITS-1:0] w_acc_sh;
    logic [CNT_BITS-1:0] w_cnt_sh;
    logic                w_emit_fire;
    logic                w_accept;

    assign o_beat_vld  = (r_cnt >= BEAT_CNT) || (r_flush && (r_cnt != '0));
    assign o_beat_last = r_flush && (r_cnt <= BEAT_CNT);
    assign o_beat_dat  = r_acc[BEAT_BITS-1:0];
    assign w_emit_fire = o_beat_vld && i_beat_rdy;

    // A pixel may land in the same cycle a full beat leaves, since the
    // remaining residue is then always narrower than one beat.
    assign o_s_ready = r_run && !r_flush && i_beat_rdy &&
                       ((r_cnt < BEAT_CNT) || w_emit_fire);
    assign w_accept  = i_s_valid && o_s_ready;

    always_comb begin
        w_acc_sh = r_acc;
        w_cnt_sh = r_cnt;
        if (w_emit_fire) begin
            if (o_beat_last) begin
                w_acc_sh = '0;
                w_cnt_sh = '0;
            end else begin
                w_acc_sh = r_acc >> BEAT_BITS;
                w_cnt_sh = r_cnt - BEAT_CNT;
            end
        end
    end

    always_ff @(posedge dphy_clk) begin
        if (!aresetn) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_acc   <= w_acc_sh | (ACC_BITS'(i_s_data) << w_cnt_sh);
                r_cnt   <= w_cnt_sh + PIX_CNT;
                r_flush <= i_s_last;
            end else begin
                r_acc <= w_acc_sh;
                r_cnt <= w_cnt_sh;
                if (w_emit_fire && o_beat_last)
                    r_flush <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rtcl_p3s7_hs_dphy_send.sv
// Store-and-forward HS sender: packs pixels, buffers whole lines, sends each as
// header + contiguous payload burst followed by a fixed gap. Backpressure only on s_ready.
module rtcl_p3s7_hs_dphy_send
    import rtcl_p3s7_hs_pkg::*;
#(
    parameter int CHANNELS      = 1,
    parameter int RAW_BITS      = 10,
    parameter int DPHY_LANES    = 2,
    parameter int FIFO_PTR_BITS = 10,
    parameter int GAP_CYCLES    = GAP_CYCLES_DEF
) (
    input  logic                       dphy_clk,
    input  logic                       aresetn,
    input  logic [DPHY_LANES-1:0][7:0] header_data,
    input  logic                       s_last,
    input  logic [CHANNELS*RAW_BITS-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       dphy_request,
    input  logic                       dphy_ready,
    output logic [DPHY_LANES-1:0][7:0] dphy_data,
    output logic                       dphy_valid,
    output logic                       busy
);
    localparam int BEAT_BITS = beat_bits(DPHY_LANES);
    localparam int PIX_BITS  = pix_bits(CHANNELS, RAW_BITS);
    localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [BEAT_BITS-1:0]         w_pk_dat;
    logic                         w_pk_last;
    logic                         w_pk_vld;
    logic                         w_fifo_wr_rdy;
    logic                         w_fifo_full;
    logic                         w_rd_vld;
    logic [BEAT_BITS:0]           w_rd_dat;
    logic                         w_pop;
    logic                         w_inc;
    logic                         w_dec;
    logic [2:0]                   r_state;
    logic [DPHY_LANES-1:0][7:0]   r_hdr;
    logic [GAP_W-1:0]             r_gap_cnt;
    logic [FIFO_PTR_BITS:0]       r_line_count;

    rtcl_p3s7_hs_pack #(
        .PIX_BITS  (PIX_BITS),
        .BEAT_BITS (BEAT_BITS)
    ) u_pack (
        .dphy_clk    (dphy_clk),
        .aresetn     (aresetn),
        .i_s_data    (s_data),
        .i_s_last    (s_last),
        .i_s_valid   (s_valid),
        .o_s_ready   (s_ready),
        .o_beat_dat  (w_pk_dat),
        .o_beat_last (w_pk_last),
        .o_beat_vld  (w_pk_vld),
        .i_beat_rdy  (w_fifo_wr_rdy)
    );

    // The last flag rides along as the top bit of each FIFO word.
    fifo_fwft #(
        .WIDTH    (BEAT_BITS + 1),
        .PTR_BITS (FIFO_PTR_BITS)
    ) u_fifo (
        .i_clk    (dphy_clk),
        .i_resetn (aresetn),
        .i_wr_vld (w_pk_vld),
        .i_wr_dat ({w_pk_last, w_pk_dat}),
        .o_wr_rdy (w_fifo_wr_rdy),
        .o_rd_vld (w_rd_vld),
        .o_rd_dat (w_rd_dat),
        .i_rd_rdy (w_pop)
    );

    assign w_fifo_full = !w_fifo_wr_rdy;
    assign w_pop       = (r_state == ST_DATA) && w_rd_vld;
    assign w_inc       = w_pk_vld && w_fifo_wr_rdy && w_pk_last;
    assign w_dec       = w_pop && w_rd_dat[BEAT_BITS];

    always_ff @(posedge dphy_clk) begin
        if (!aresetn)
            r_line_count <= '0;
        else if (w_inc && !w_dec)
            r_line_count <= r_line_count + 1'b1;
        else if (w_dec && !w_inc)
            r_line_count <= r_line_count - 1'b1;
    end

    always_ff @(posedge dphy_clk) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_hdr     <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (r_line_count != '0) r_state <= ST_REQ;
                ST_REQ: begin
                    if (dphy_ready) begin
                        r_hdr   <= header_data;
                        r_state <= ST_HDR;
                    end
                end
                ST_HDR: r_state <= ST_DATA;
                ST_DATA: begin
                    if (w_dec) begin
                        r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0)
                        r_state <= ST_IDLE;
                    else
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dphy_request = (r_state == ST_REQ) || (r_state == ST_HDR) || (r_state == ST_DATA);
    assign dphy_valid   = (r_state == ST_HDR) || (r_state == ST_DATA);
    assign dphy_data    = (r_state == ST_HDR)  ? r_hdr :
                          (r_state == ST_DATA) ? w_rd_dat[BEAT_BITS-1:0] : '0;
    assign busy         = (r_state != ST_IDLE);

endmodule
